// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier.
// twos_neg works on a wide container; callers size-cast in and out.
package mult_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 6;
  localparam int NEG_W     = 128;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] x);
    return ~x + NEG_W'(1);
  endfunction
endpackage

// File: rtl/mult_unit_if.sv
// Issue-side and writeback-side handshake bundle for mult_unit.
// master = issuer/writeback side, slave = the multiplier.
interface mult_unit_if
  import mult_pkg::*;
  #(parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, a, b, signed_op, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag
  );
  modport slave (
    input  flush, in_valid, a, b, signed_op, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag
  );
endinterface

// File: rtl/mult_unit_adder.sv
// Gate-level N-bit ripple-carry adder built from full_adder cells.
// Purely combinational; no handshake.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_nbit #(parameter int N = 32) (
  output logic [N-1:0] S,
  output logic         Cout,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin
);
  logic [N:0] c;

  assign c[0] = Cin;
  assign Cout = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (.a(A[i]), .b(B[i]), .cin(c[i]), .s(S[i]), .cout(c[i+1]));
  end
endmodule

// File: rtl/mult_unit.sv
// Shift-add multiplier: one issue at a time, product valid WIDTH+1 cycles after accept.
// Holds the result in DONE until out_ready; in_ready only in IDLE, flush/reset abort.
module mult_unit
  import mult_pkg::*;
  #(parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W)
  (
  input logic       clk,
  input logic       reset,
  mult_unit_if.slave io
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier, acc_hi, sum;
  logic               cout, neg, accept, last_iter;
  logic [CNT_W-1:0]   count;
  logic [TAG_W-1:0]   tag_q, out_tag_q;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum_sel;
  logic [2*WIDTH-1:0] acc_next, product_q;

  adder_nbit #(.N(WIDTH)) u_add (
    .S(sum), .Cout(cout), .A(acc_hi), .B(mcand), .Cin(1'b0)
  );

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  always_comb begin
    a_abs = io.a;
    b_abs = io.b;
    if (io.signed_op && io.a[WIDTH-1]) a_abs = WIDTH'(twos_neg(NEG_W'(io.a)));
    if (io.signed_op && io.b[WIDTH-1]) b_abs = WIDTH'(twos_neg(NEG_W'(io.b)));
    sum_sel  = mplier[0] ? {cout, sum} : {1'b0, acc_hi};
    acc_next = {sum_sel, mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    last_iter    = 1'b0;
    io.in_ready  = (state == IDLE) && !reset;
    io.out_valid = (state == DONE);
    case (state)
      IDLE: if (io.in_valid && io.in_ready && !io.flush) begin
        accept     = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (count == CNT_W'(WIDTH - 1)) begin
        last_iter  = 1'b1;
        state_next = DONE;
      end
      DONE: if (io.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (io.flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      count     <= '0;
      neg       <= 1'b0;
      tag_q     <= '0;
      product_q <= '0;
      out_tag_q <= '0;
    end else if (accept) begin
      mcand  <= a_abs;
      mplier <= b_abs;
      acc_hi <= '0;
      count  <= '0;
      neg    <= io.signed_op & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
      tag_q  <= io.in_tag;
    end else if (state == BUSY) begin
      acc_hi <= sum_sel[WIDTH:1];
      mplier <= acc_next[WIDTH-1:0];
      count  <= count + CNT_W'(1);
      if (last_iter && !io.flush) begin
        product_q <= neg ? (2*WIDTH)'(twos_neg(NEG_W'(acc_next))) : acc_next;
        out_tag_q <= tag_q;
      end
    end
  end

  assign io.product = product_q;
  assign io.out_tag = out_tag_q;
endmodule

// File: tb/tb_mult_unit.sv
// Randomized and directed bench for mult_unit at WIDTH=8 against an arithmetic reference.
module tb_mult_unit;
  localparam int W  = 8;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(W), .TAG_W(TW)) io ();
  mult_unit #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .io(io));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xi, yi;
    if (s) begin
      xi = longint'($signed(x));
      yi = longint'($signed(y));
    end else begin
      xi = longint'(x);
      yi = longint'(y);
    end
    return (2*W)'(xi * yi);
  endfunction

  // Drives an op at a negedge and returns after the accepting posedge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input logic [TW-1:0] t);
    chk("in_ready_idle", 64'(io.in_ready), 64'd1);
    io.in_valid = 1'b1; io.a = x; io.b = y; io.signed_op = s; io.in_tag = t;
    @(posedge clk);
  endtask

  // Counts negedges after accept until out_valid; optionally spams in_valid meanwhile.
  task automatic wait_done(input bit noise, output int lat);
    @(negedge clk);
    lat = 1;
    io.in_valid = noise;
    while (!io.out_valid && lat < 40) begin
      if (noise) begin
        io.a = W'($urandom); io.b = W'($urandom);
        io.signed_op = 1'($urandom); io.in_tag = TW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    io.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [TW-1:0] t, input int bp, input bit noise);
    int lat;
    logic [2*W-1:0] exp;
    exp = ref_mul(x, y, s);
    io.out_ready = 1'b0;
    start_op(x, y, s, t);
    wait_done(noise, lat);
    chk("latency", 64'(lat), 64'd9);
    chk("product", 64'(io.product), 64'(exp));
    chk("out_tag", 64'(io.out_tag), 64'(t));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(io.out_valid), 64'd1);
      chk("bp_product", 64'(io.product), 64'(exp));
      chk("bp_tag", 64'(io.out_tag), 64'(t));
      chk("bp_in_ready", 64'(io.in_ready), 64'd0);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("drain_valid", 64'(io.out_valid), 64'd0);
    chk("drain_in_ready", 64'(io.in_ready), 64'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    io.flush = 1'b0; io.in_valid = 1'b0; io.a = '0; io.b = '0;
    io.signed_op = 1'b0; io.in_tag = '0; io.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(io.in_ready), 64'd0);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_product", 64'(io.product), 64'd0);
    chk("rst_out_tag", 64'(io.out_tag), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'd3, 8'd5, 1'b0, 6'h2A, 0, 1'b0);
    chk("const_3x5", 64'(ref_mul(8'd3, 8'd5, 1'b0)), 64'h000F);
    run_op(8'hFF, 8'hFF, 1'b0, 6'h01, 0, 1'b0);
    chk("const_ff", 64'(ref_mul(8'hFF, 8'hFF, 1'b0)), 64'hFE01);
    run_op(8'hFD, 8'h05, 1'b1, 6'h02, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 6'h03, 0, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 6'h04, 0, 1'b0);
    run_op(8'h00, 8'h9C, 1'b1, 6'h05, 0, 1'b0);
    run_op(8'hC5, 8'h3B, 1'b0, 6'h06, 5, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 6'h07, 0, 1'b1);

    // Flush in the 4th BUSY cycle.
    start_op(8'd9, 8'd9, 1'b0, 6'h10);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    io.flush = 1'b1;
    @(negedge clk);
    io.flush = 1'b0;
    chk("flush_idle", 64'(io.in_ready), 64'd1);
    chk("flush_valid", 64'(io.out_valid), 64'd0);
    expect_quiet("flush_quiet", 12);
    run_op(8'd7, 8'd6, 1'b0, 6'h11, 0, 1'b0);

    // Flush coincident with an issue in IDLE.
    io.in_valid = 1'b1; io.a = 8'd2; io.b = 8'd2; io.flush = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0; io.flush = 1'b0;
    chk("flush_issue_idle", 64'(io.in_ready), 64'd1);
    expect_quiet("flush_issue_quiet", 12);

    // Flush wins over the output handshake.
    io.out_ready = 1'b0;
    start_op(8'd11, 8'd13, 1'b0, 6'h12);
    wait_done(1'b0, lat);
    chk("pre_flush_done", 64'(io.out_valid), 64'd1);
    io.flush = 1'b1; io.out_ready = 1'b1;
    @(negedge clk);
    io.flush = 1'b0; io.out_ready = 1'b0;
    chk("flush_done_valid", 64'(io.out_valid), 64'd0);
    chk("flush_done_ready", 64'(io.in_ready), 64'd1);

    // Reset mid-BUSY.
    start_op(8'd200, 8'd100, 1'b0, 6'h33);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstb_valid", 64'(io.out_valid), 64'd0);
    chk("rstb_product", 64'(io.product), 64'd0);
    chk("rstb_tag", 64'(io.out_tag), 64'd0);
    chk("rstb_in_ready", 64'(io.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstb_after", 64'(io.in_ready), 64'd1);

    // Reset while holding a result in DONE.
    start_op(8'd200, 8'd100, 1'b0, 6'h34);
    wait_done(1'b0, lat);
    chk("rstd_pre_product", 64'(io.product), 64'(ref_mul(8'd200, 8'd100, 1'b0)));
    reset = 1'b1;
    @(negedge clk);
    chk("rstd_valid", 64'(io.out_valid), 64'd0);
    chk("rstd_product", 64'(io.product), 64'd0);
    chk("rstd_tag", 64'(io.out_tag), 64'd0);
    chk("rstd_in_ready", 64'(io.in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstd_after", 64'(io.in_ready), 64'd1);

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), TW'($urandom),
             int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
